// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer, bounded grant hold
// and a mandatory idle turnaround cycle between grants.
module ring_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned IDW      = 2
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           ENABLE,
    input  logic [N-1:0]   REQ,
    input  logic           DONE,
    output logic [N-1:0]   GNT,
    output logic           GNT_VALID,
    output logic [IDW-1:0] GNT_ID,
    output logic [N-1:0]   PTR,
    output logic           TIMEOUT
);

    localparam int unsigned CW = $clog2(MAX_HOLD) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           valid_q, valid_d;
    logic [IDW-1:0] id_q, id_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic           to_q, to_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [IDW-1:0] ptr_idx;
    logic [IDW-1:0] win_idx;
    logic [N-1:0]   win_oh;
    logic           win_found;
    logic           rel_done, rel_wd, rel_to;
    int             j;

    // First requester at or after the pointer, wrapping from N-1 back to 0.
    always_comb begin
        ptr_idx   = '0;
        win_idx   = '0;
        win_found = 1'b0;
        win_oh    = '0;
        j         = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (ptr_q[i]) ptr_idx = IDW'(i);
        end
        for (int k = 0; k < int'(N); k++) begin
            j = int'(ptr_idx) + k;
            if (j >= int'(N)) j = j - int'(N);
            if (!win_found && REQ[IDW'(j)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(j);
            end
        end
        win_oh[win_idx] = 1'b1;
    end

    assign rel_done = DONE;
    assign rel_wd   = !REQ[id_q];
    assign rel_to   = (cnt_q == CW'(MAX_HOLD));

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        to_d    = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ENABLE && win_found) begin
                    gnt_d   = win_oh;
                    valid_d = 1'b1;
                    id_d    = win_idx;
                    cnt_d   = CW'(1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rel_done || rel_wd || rel_to) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = {gnt_q[N-2:0], gnt_q[N-1]};
                    to_d    = rel_to && !rel_done && !rel_wd;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != CW'(MAX_HOLD)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= N'(1);
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign GNT       = gnt_q;
    assign GNT_VALID = valid_q;
    assign GNT_ID    = id_q;
    assign PTR       = ptr_q;
    assign TIMEOUT   = to_q;

endmodule
